// File: rtl/program_loader.sv
// program_loader: streams a little-endian byte image into instruction memory and
// holds the core in reset until a checksum-verified load completes.
module program_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR} state_t;
  state_t state, nxt;
  logic [1:0] cnt;
  logic [31:0] w, sum, full;
  logic [ADDR_WIDTH:0] n, idx;
  logic take, last, restart;
  assign full = {in_data, w[31:8]};
  assign take = in_valid && in_ready;
  assign last = take && cnt == 2'd3;
  assign restart = start && (state == IDLE || state == DONE || state == ERR);
  assign in_ready = state == HDR || state == DATA || state == CSUM;
  assign busy = in_ready || state == WRITE;
  assign im_we = state == WRITE;
  assign done = state == DONE;
  assign error = state == ERR;
  assign cpu_rst = state != DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = start ? HDR : state;
      HDR: if (last) nxt = full == 32'd0 ? CSUM :
                           {1'b0, full} > (33'd1 << ADDR_WIDTH) ? ERR : DATA;
      DATA: nxt = last ? WRITE : DATA;
      WRITE: nxt = idx + 1'b1 == n ? CSUM : DATA;
      CSUM: if (last) nxt = full == sum ? DONE : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      w <= '0;
      sum <= '0;
      n <= '0;
      idx <= '0;
      im_addr <= '0;
      im_wdata <= '0;
    end else begin
      state <= nxt;
      if (restart) begin
        cnt <= '0;
        sum <= '0;
        idx <= '0;
      end
      if (take) begin
        w <= full;
        cnt <= cnt + 2'd1;
      end
      if (state == HDR && last) n <= full[ADDR_WIDTH:0];
      // latch the outgoing word so address/data stay stable after the strobe
      if (state == DATA && last) begin
        im_addr <= 32'({idx[ADDR_WIDTH-1:0], 2'b00});
        im_wdata <= full;
      end
      if (state == WRITE) begin
        sum <= sum + w;
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed loads checked against a stream-level model of the image.
module tb_program_loader;
  typedef logic [7:0] bq_t[$];
  logic CLK, reset, start, in_valid;
  logic [7:0] in_data;
  logic in_ready, im_we, cpu_rst, busy, done, error;
  logic [31:0] im_addr, im_wdata;
  int n_tests = 0, n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wlog[$];
  bit exp_done, exp_err;

  program_loader #(.ADDR_WIDTH(10)) dut (
    .CLK(CLK), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // image-level model: decode the stream into expected writes and outcome
  task automatic model(input bq_t b);
    logic [31:0] nw, s, word, cs;
    nw = {b[3], b[2], b[1], b[0]};
    exp_err = nw > 32'd1024;
    exp_done = 0;
    if (!exp_err) begin
      s = 0;
      for (int i = 0; i < int'(nw); i++) begin
        word = {b[4+4*i+3], b[4+4*i+2], b[4+4*i+1], b[4+4*i]};
        exp_q.push_back({32'(i * 4), word});
        s += word;
      end
      cs = {b[4+4*nw+3], b[4+4*nw+2], b[4+4*nw+1], b[4+4*nw]};
      exp_done = cs == s;
      exp_err = !exp_done;
    end
  endtask

  always @(negedge CLK) begin
    if (reset && im_we) begin
      wlog.push_back({im_addr, im_wdata});
      chk("no_accept_in_write", {63'd0, in_ready}, 64'd0);
      if (exp_q.size() == 0) chk("unexpected_write", {im_addr, im_wdata}, 64'd0);
      else chk("write", {im_addr, im_wdata}, exp_q.pop_front());
    end
  end

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_rst"}, {58'd0, in_ready, im_we, done, error, busy, cpu_rst}, 64'b000001);
  endtask

  task automatic run(input bq_t b, input bit gap, input int abort_at, input int exp_edges,
                     input string nm);
    int i = 0, e = 0, lim;
    bit acc;
    lim = abort_at != 0 ? abort_at : b.size();
    if (abort_at == 0) model(b);
    @(negedge CLK) start = 1;
    @(negedge CLK) start = 0;
    while (i < lim && e < 2000) begin
      in_valid = !gap || (e % 2 == 0);
      in_data = b[i];
      acc = in_valid && in_ready;
      @(posedge CLK);
      e++;
      if (acc) i++;
      @(negedge CLK);
    end
    in_valid = 0;
    if (e >= 2000) chk({nm, "_timeout"}, 64'(e), 64'(exp_edges));
    else if (abort_at != 0) begin
      #1 reset = 0;
      #1 check_reset_outputs(nm);
      @(negedge CLK) reset = 1;
    end else begin
      chk({nm, "_edges"}, 64'(e), 64'(exp_edges));
      chk({nm, "_status"}, {60'd0, done, error, cpu_rst, busy},
          {60'd0, exp_done, exp_err, !exp_done, 1'b0});
      chk({nm, "_ready"}, {63'd0, in_ready}, 64'd0);
      chk({nm, "_all_writes"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    bq_t good, bad, empty, big, one;
    good = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00, 8'hA6, 8'h00, 8'h10, 8'h00};
    bad = good;
    bad[12] = 8'hA7;
    empty = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    big = '{8'h01, 8'h04, 8'h00, 8'h00};
    one = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    reset = 1;
    start = 0;
    in_valid = 0;
    in_data = 0;
    #3 reset = 0;
    #1 check_reset_outputs("power_up");
    chk("power_up_bus", {im_addr, im_wdata}, 64'd0);
    @(negedge CLK);
    @(negedge CLK) reset = 1;
    run(good, 0, 0, 18, "good2");
    chk("good2_log_n", 64'(wlog.size()), 64'd2);
    chk("good2_w0", wlog[0], 64'h00000000_00000013);
    chk("good2_w1", wlog[1], 64'h00000004_00100093);
    chk("good2_hold", {im_addr, im_wdata}, 64'h00000004_00100093);
    chk("good2_done_lit", {62'd0, done, cpu_rst}, 64'b10);
    run(bad, 0, 0, 18, "badsum");
    chk("badsum_err_lit", {61'd0, done, error, cpu_rst}, 64'b011);
    run(good, 0, 0, 18, "retry");
    run(empty, 0, 0, 8, "empty");
    run(big, 0, 0, 4, "toolarge");
    chk("toolarge_err_lit", {62'd0, error, in_ready}, 64'b10);
    run(good, 1, 0, 31, "gapped");
    run(one, 0, 0, 13, "one_word");
    run(good, 0, 6, 0, "abort");
    chk("abort_no_write", 64'(wlog.size()), 64'd9);
    run(good, 0, 0, 18, "after_abort");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program writer for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory through a dedicated write port. It holds the core in reset while loading and releases it only after a checksum-verified load. It is the write-side counterpart of the core's instruction fetch path.

## Interface
- ADDR_WIDTH, 10, word-address bits of instruction memory; capacity is 2^ADDR_WIDTH words
- CLK  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state and outputs to reset values immediately
- start  in  1  begin a load; honoured only in IDLE, DONE or ERR
- in_valid  in  1  byte on in_data is valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte; a byte transfers on a rising edge with in_valid=1 and in_ready=1
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  32  byte address, word-aligned: {word_idx, 2'b00}, zero-extended
- im_wdata  out  32  word to write
- cpu_rst  out  1  1 holds the core in reset
- busy  out  1  load in progress
- done  out  1  last load completed with a good checksum
- error  out  1  last load failed

## Operation
- Stream format: 4-byte word count N, then N words of 4 bytes, then a 4-byte checksum. All fields little-endian: byte k of a field lands in bits [8k+7:8k].
- Checksum is the sum of all N words mod 2^32. An empty program has checksum 0.
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start=1 -> HDR. On this transition word_idx, the running sum, the byte counter, done and error are cleared, and cpu_rst is set to 1.
- start is ignored in HDR, DATA, WRITE and CSUM.
- HDR: 4 bytes accepted, then N is latched.
  - N=0 -> CSUM.
  - N>2^ADDR_WIDTH -> ERR, with no writes.
  - Otherwise -> DATA.
- DATA: 4 bytes assemble a word, then -> WRITE.
- WRITE: lasts one cycle. During it:
  - im_we=1, im_addr={word_idx,2'b00}, im_wdata=word.
  - The running sum adds the word, and word_idx increments.
  - Next state is CSUM if the incremented word_idx equals N, else DATA.
- CSUM: 4 bytes are accepted and compared with the running sum. Equal -> DONE; unequal -> ERR.
- DONE: done=1, cpu_rst=0; the state is held until start.
- ERR: error=1, cpu_rst=1; the state is held until start.
- in_ready is a Moore output: 1 only in HDR, DATA and CSUM. It is 0 in WRITE, IDLE, DONE and ERR.
- busy=1 in HDR, DATA, WRITE and CSUM.
- im_addr and im_wdata hold their last values when im_we=0.
- Reset values: state IDLE; in_ready 0, im_we 0, im_addr 0, im_wdata 0, busy 0, done 0, error 0, cpu_rst 1.
  - The core therefore stays held from power-up until the first successful load.
- Reset during a load: the loader returns to IDLE and discards any partial word, the sum and the count. Words already written are not rolled back, and cpu_rst stays 1.

## Timing
- If start is sampled at edge t, the state is HDR after t, and the first byte can transfer at edge t+1.
- With in_valid held at 1:
  - the header takes 4 cycles;
  - each word takes 5 cycles (4 byte transfers plus 1 WRITE cycle);
  - the checksum takes 4 cycles.
  - Total from start to done = 1 + 4 + 5N + 4 edges.
- done/error and the cpu_rst change become visible on the cycle after the edge that accepts the 4th checksum byte.
- in_valid gaps stall the byte counter without changing state. in_data is don't-care while in_valid=0 or in_ready=0.
- Exactly one im_we pulse per word; the address increments by 4 between pulses.

## Test plan
- Reset asserted (reset=0) mid-cycle -> immediately in_ready=0, im_we=0, done=0, error=0, busy=0, cpu_rst=1.
- start, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | A6 00 10 00 with continuous valid:
  - im_we pulses (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00100093);
  - done=1 and cpu_rst=0 at edge 18 after start.
- Same load with checksum bytes A7 00 10 00 -> both writes occur, then error=1, done=0, cpu_rst=1. A following start plus the correct stream -> done=1.
- Header 00 00 00 00 plus checksum 00 00 00 00 -> done=1 with no im_we. Header N=1025 (ADDR_WIDTH=10) -> error=1 after the 4th header byte, no im_we, in_ready=0.
- in_valid toggling 1/0 every cycle -> same writes and data as the continuous case. No byte is accepted while in WRITE, and the total time is extended by the number of gaps.
- reset pulsed low after the 2nd data byte of word 1 -> IDLE, cpu_rst=1. A subsequent start plus a full 2-word stream -> correct writes and done=1.
